pipelined_decoder: RTL and testbench

- Registered decode stage between instruction fetch and execute in the lib_cpu core.
- Accepts one instruction word (plus its PC) per cycle over a valid/ready handshake and decodes it into an OPECODE, immediate and jump flag.
- A 2-entry skid buffer fully decouples back-pressure: the input ready is registered, yet the stage sustains one instruction per cycle.
- Adds flush (taken jump / redirect) and a saturating illegal-instruction counter.

---
 rtl/pipelined_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_pipelined_decoder.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_decoder.sv
// Registered instruction decode stage with a 2-entry skid buffer.
//
// Sits between fetch and execute. Words arrive over a valid/ready handshake,
// are decoded on entry and stored already decoded. All outputs come straight
// from registers. A second (skid) entry lets in_ready be registered while the
// stage still sustains one instruction per cycle.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  fetch handshake (in_ready is registered)
//   in_word, in_pc  instruction word and its PC
//   flush           drop everything held and anything arriving this cycle
//   out_valid/ready execute handshake
//   out_opecode     decoded operation (INVALID for unmapped codes)
//   out_imm, out_pc immediate field and PC of the presented instruction
//   out_is_jump     operation is JMP_IMM or JNC_IMM
//   ill_count       saturating count of INVALID instructions delivered

package pipelined_decoder_pkg;
    typedef enum logic [3:0] {
        ADD_A_IMM = 4'd0,
        MOV_A_B   = 4'd1,
        IN_A      = 4'd2,
        MOV_A_IMM = 4'd3,
        MOV_B_A   = 4'd4,
        ADD_B_IMM = 4'd5,
        IN_B      = 4'd6,
        MOV_B_IMM = 4'd7,
        OUT_B     = 4'd8,
        OUT_IMM   = 4'd9,
        JNC_IMM   = 4'd10,
        JMP_IMM   = 4'd11,
        INVALID   = 4'd15
    } opecode_t;
endpackage

// state | meaning
// EMPTY | no instruction held, out_valid=0
// ONE   | output entry holds an instruction, skid entry free
// TWO   | output and skid entries both full, in_ready=0
module pipelined_decoder
    import pipelined_decoder_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter int IMM_W     = WORD_W - 4,
    parameter int PC_W      = 4,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_W-1:0]    in_word,
    input  logic [PC_W-1:0]      in_pc,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output opecode_t             out_opecode,
    output logic [IMM_W-1:0]     out_imm,
    output logic [PC_W-1:0]      out_pc,
    output logic                 out_is_jump,
    output logic [ILL_CNT_W-1:0] ill_count
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    function automatic opecode_t decode_op(input logic [3:0] code);
        case (code)
            4'b0000: return ADD_A_IMM;
            4'b0001: return MOV_A_B;
            4'b0010: return IN_A;
            4'b0011: return MOV_A_IMM;
            4'b0100: return MOV_B_A;
            4'b0101: return ADD_B_IMM;
            4'b0110: return IN_B;
            4'b0111: return MOV_B_IMM;
            4'b1001: return OUT_B;
            4'b1011: return OUT_IMM;
            4'b1110: return JNC_IMM;
            4'b1111: return JMP_IMM;
            default: return INVALID;
        endcase
    endfunction

    state_t           state, state_next;
    logic             in_xfer, out_xfer;
    logic             load_out_in, load_skid, promote;

    opecode_t         dec_op;
    logic [IMM_W-1:0] dec_imm;
    logic             dec_jump;

    opecode_t         skid_op;
    logic [IMM_W-1:0] skid_imm;
    logic [PC_W-1:0]  skid_pc;
    logic             skid_jump;

    // Bits between the opcode field and the immediate are deliberately unused.
    assign dec_op   = decode_op(in_word[WORD_W-1 -: 4]);
    assign dec_imm  = in_word[IMM_W-1:0];
    assign dec_jump = (dec_op == JMP_IMM) || (dec_op == JNC_IMM);

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        load_out_in = 1'b0;
        load_skid   = 1'b0;
        promote     = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        state_next  = ONE;
                        load_out_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_xfer && !out_xfer) begin
                        state_next = TWO;
                        load_skid  = 1'b1;
                    end else if (!in_xfer && out_xfer) begin
                        state_next = EMPTY;
                    end else if (in_xfer && out_xfer) begin
                        load_out_in = 1'b1;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        state_next = ONE;
                        promote    = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // Handshake flags are registered copies of the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            out_valid <= (state_next != EMPTY);
            in_ready  <= (state_next != TWO);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_opecode <= INVALID;
            out_imm     <= '0;
            out_pc      <= '0;
            out_is_jump <= 1'b0;
            skid_op     <= INVALID;
            skid_imm    <= '0;
            skid_pc     <= '0;
            skid_jump   <= 1'b0;
        end else begin
            if (load_out_in) begin
                out_opecode <= dec_op;
                out_imm     <= dec_imm;
                out_pc      <= in_pc;
                out_is_jump <= dec_jump;
            end else if (promote) begin
                out_opecode <= skid_op;
                out_imm     <= skid_imm;
                out_pc      <= skid_pc;
                out_is_jump <= skid_jump;
            end
            if (load_skid) begin
                skid_op   <= dec_op;
                skid_imm  <= dec_imm;
                skid_pc   <= in_pc;
                skid_jump <= dec_jump;
            end
        end
    end

    // Counts deliveries, so an output transfer in a flush cycle still counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            ill_count <= '0;
        end else if (out_xfer && (out_opecode == INVALID) && (ill_count != '1)) begin
            ill_count <= ill_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipelined_decoder.sv
module tb_pipelined_decoder;
    import pipelined_decoder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic       rst, in_valid, in_ready, flush, out_valid, out_ready, out_is_jump;
    logic [7:0] in_word;
    logic [3:0] in_pc, out_imm, out_pc;
    logic [7:0] ill_count;
    opecode_t   out_opecode;

    pipelined_decoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_opecode(out_opecode), .out_imm(out_imm),
        .out_pc(out_pc), .out_is_jump(out_is_jump), .ill_count(ill_count)
    );

    // Wide-word, narrow-counter instance
    logic        rst2, in_valid2, in_ready2, flush2, out_valid2, out_ready2, out_is_jump2;
    logic [11:0] in_word2;
    logic [3:0]  in_pc2, out_pc2;
    logic [7:0]  out_imm2;
    logic [1:0]  ill_count2;
    opecode_t    out_opecode2;

    pipelined_decoder #(.WORD_W(12), .IMM_W(8), .PC_W(4), .ILL_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_word(in_word2), .in_pc(in_pc2), .flush(flush2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_opecode(out_opecode2), .out_imm(out_imm2),
        .out_pc(out_pc2), .out_is_jump(out_is_jump2), .ill_count(ill_count2)
    );

    typedef struct packed {
        opecode_t   op;
        logic [3:0] imm;
        logic [3:0] pc;
        logic       jmp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_delivered = 0;
    int   exp_ill = 0;

    function automatic opecode_t model_op(input logic [3:0] n);
        opecode_t t;
        case (n)
            4'h0: t = ADD_A_IMM;  4'h1: t = MOV_A_B;
            4'h2: t = IN_A;       4'h3: t = MOV_A_IMM;
            4'h4: t = MOV_B_A;    4'h5: t = ADD_B_IMM;
            4'h6: t = IN_B;       4'h7: t = MOV_B_IMM;
            4'h9: t = OUT_B;      4'hB: t = OUT_IMM;
            4'hE: t = JNC_IMM;    4'hF: t = JMP_IMM;
            default: t = INVALID;
        endcase
        return t;
    endfunction

    // Scoreboard: pops/compares deliveries, then pushes accepted inputs.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            exp_ill = 0;
        end else begin
            if (out_valid && out_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: got op=%s imm=%h pc=%h, required no delivery",
                             out_opecode.name(), out_imm, out_pc);
                end else begin
                    e = sb.pop_front();
                    n_delivered++;
                    if (e.op == INVALID && exp_ill < 255) exp_ill++;
                    if ({out_opecode, out_imm, out_pc, out_is_jump} !== e) begin
                        n_err++;
                        $display("FAIL sb_output: got op=%s imm=%h pc=%h jmp=%b, required op=%s imm=%h pc=%h jmp=%b",
                                 out_opecode.name(), out_imm, out_pc, out_is_jump,
                                 e.op.name(), e.imm, e.pc, e.jmp);
                    end
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) begin
                e.op  = model_op(in_word[7:4]);
                e.imm = in_word[3:0];
                e.pc  = in_pc;
                e.jmp = (e.op == JMP_IMM) || (e.op == JNC_IMM);
                sb.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0 && !out_valid) break;
            tick();
        end
        n_cmp++;
        if (sb.size() != 0 || out_valid) begin
            n_err++;
            $display("FAIL drain: got %0d pending, out_valid=%b, required 0 pending, out_valid=0",
                     sb.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_word = 8'hF5; in_pc = 4'h3;
        flush = 1'b0; out_ready = 1'b1;
        tick();
        n_cmp++;
        if ({out_valid, in_ready, ill_count, out_opecode, out_imm, out_pc, out_is_jump}
            !== {1'b0, 1'b1, 8'h00, INVALID, 4'h0, 4'h0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_values: got v=%b rdy=%b ill=%0d op=%s imm=%h pc=%h j=%b, required 0 1 0 INVALID 0 0 0",
                     out_valid, in_ready, ill_count, out_opecode.name(), out_imm, out_pc, out_is_jump);
        end
        rst = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_stream();
        logic [7:0] words [4] = '{8'h3A, 8'h71, 8'h10, 8'hF5};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_word = words[i]; in_pc = 4'(i);
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL stream_rate[%0d]: got v=%b rdy=%b, required 1 1", i, out_valid, in_ready);
            end
        end
        n_cmp++;
        if (out_is_jump !== 1'b1 || out_opecode !== JMP_IMM) begin
            n_err++;
            $display("FAIL stream_jump: got op=%s j=%b, required JMP_IMM 1", out_opecode.name(), out_is_jump);
        end
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_all_opcodes();
        do_reset();
        out_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            in_valid = 1'b1; in_word = {4'(n), 4'h7}; in_pc = 4'(n);
            tick();
        end
        in_valid = 1'b0;
        drain();
        n_cmp++;
        if (ill_count !== 8'd4 || ill_count !== 8'(exp_ill)) begin
            n_err++;
            $display("FAIL all_opcodes_ill: got %0d, required 4 (model %0d)", ill_count, exp_ill);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        bit acc;
        do_reset();
        d0 = n_delivered;
        in_valid = 1'b1; in_word = 8'h01; in_pc = 4'h0;
        tick();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_first: got rdy=%b v=%b, required 1 1", in_ready, out_valid);
        end
        in_word = 8'h52; in_pc = 4'h1;
        tick();
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_ready_low: got %b, required 0", in_ready);
        end
        in_word = 8'h63; in_pc = 4'h2;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++;
            if (in_ready !== 1'b0 || out_opecode !== ADD_A_IMM || out_imm !== 4'h1 || out_pc !== 4'h0) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got rdy=%b op=%s imm=%h pc=%h, required 0 ADD_A_IMM 1 0",
                         k, in_ready, out_opecode.name(), out_imm, out_pc);
            end
        end
        out_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 10 && !acc; k++) begin
            acc = in_ready;
            tick();
        end
        n_cmp++;
        if (!acc) begin
            n_err++;
            $display("FAIL bp_third_accept: got not accepted, required accepted within 10 cycles");
        end
        in_valid = 1'b0;
        drain();
        n_cmp++;
        if (n_delivered - d0 != 3) begin
            n_err++;
            $display("FAIL bp_count: got %0d delivered, required 3", n_delivered - d0);
        end
    endtask

    task automatic test_flush();
        // Flush from TWO
        do_reset();
        in_valid = 1'b1; in_word = 8'h01; in_pc = 4'h0; tick();
        in_word = 8'h52; in_pc = 4'h1; tick();
        in_word = 8'hE4; in_pc = 4'h2; flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_two: got v=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
        // Flush from ONE where the incoming word would otherwise be taken
        do_reset();
        in_valid = 1'b1; in_word = 8'h01; in_pc = 4'h0; tick();
        in_word = 8'hE4; in_pc = 4'h1; flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL flush_drop[%0d]: got out_valid=%b op=%s, required 0", k, out_valid, out_opecode.name());
            end
            tick();
        end
        // Delivery in the flush cycle still counts
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_word = 8'h80; in_pc = 4'h4; tick();
        in_valid = 1'b0; flush = 1'b1; tick();
        flush = 1'b0;
        n_cmp++;
        if (ill_count !== 8'd1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_delivered: got ill=%0d v=%b, required 1 0", ill_count, out_valid);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        in_valid = 1'b1; in_word = 8'h3A; in_pc = 4'h0; tick();
        in_word = 8'h71; in_pc = 4'h1; tick();
        rst = 1'b1; in_word = 8'h10; in_pc = 4'h2; tick();
        n_cmp++;
        if ({out_valid, in_ready, ill_count, out_opecode, out_imm, out_pc, out_is_jump}
            !== {1'b0, 1'b1, 8'h00, INVALID, 4'h0, 4'h0, 1'b0}) begin
            n_err++;
            $display("FAIL mid_reset: got v=%b rdy=%b ill=%0d op=%s imm=%h pc=%h j=%b, required 0 1 0 INVALID 0 0 0",
                     out_valid, in_ready, ill_count, out_opecode.name(), out_imm, out_pc, out_is_jump);
        end
        rst = 1'b0; out_ready = 1'b1;
        in_word = 8'hE2; in_pc = 4'h7; tick();
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_wide_and_saturation();
        logic [1:0] want;
        rst2 = 1'b1; in_valid2 = 1'b0; flush2 = 1'b0; out_ready2 = 1'b1;
        in_word2 = '0; in_pc2 = '0;
        tick();
        rst2 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            in_valid2 = 1'b1; in_word2 = 12'h800; in_pc2 = 4'(k);
            tick();
            in_valid2 = 1'b0;
            n_cmp++;
            if (out_valid2 !== 1'b1 || out_opecode2 !== INVALID) begin
                n_err++;
                $display("FAIL wide_invalid[%0d]: got v=%b op=%s, required 1 INVALID", k, out_valid2, out_opecode2.name());
            end
            tick();
            want = (k < 3) ? 2'(k) : 2'd3;
            n_cmp++;
            if (ill_count2 !== want) begin
                n_err++;
                $display("FAIL ill_sat[%0d]: got %0d, required %0d", k, ill_count2, want);
            end
        end
        in_valid2 = 1'b1; in_word2 = 12'hB5A; in_pc2 = 4'h9;
        tick();
        in_valid2 = 1'b0;
        n_cmp++;
        if ({out_valid2, out_opecode2, out_imm2, out_pc2, out_is_jump2}
            !== {1'b1, OUT_IMM, 8'h5A, 4'h9, 1'b0}) begin
            n_err++;
            $display("FAIL wide_decode: got v=%b op=%s imm=%h pc=%h j=%b, required 1 OUT_IMM 5a 9 0",
                     out_valid2, out_opecode2.name(), out_imm2, out_pc2, out_is_jump2);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_word = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        rst2 = 1'b1; in_valid2 = 1'b0; in_word2 = '0; in_pc2 = '0; flush2 = 1'b0; out_ready2 = 1'b0;
        tick();
        test_reset();
        test_stream();
        test_all_opcodes();
        test_back_to_back();
        test_flush();
        test_mid_reset();
        test_wide_and_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
